// File: rtl/cov_acc_pkg.sv
// Shared types and helpers for the coverage-sum accumulator.
// Provides the controller state encoding and the saturating counter step.
package cov_acc_pkg;

    localparam int COV_SUM_W = 30;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } cov_acc_state_e;

    // Adds one and holds at the all-ones value of an i_width-bit counter.
    function automatic logic [COV_SUM_W-1:0] sat_inc(
        input logic [COV_SUM_W-1:0] i_val,
        input int unsigned          i_width
    );
        logic [COV_SUM_W-1:0] w_max;
        w_max = {COV_SUM_W{1'b1}} >> (COV_SUM_W - i_width);
        return (i_val >= w_max) ? w_max : i_val + 1'b1;
    endfunction

endpackage

// File: rtl/cov_bitmap_ram.sv
// One-bit-wide hit bitmap: one synchronous read port, one write port.
// A read and a write to the same address on the same edge return the old bit.
module cov_bitmap_ram #(
    parameter int IDX_W = 16
) (
    input  logic             i_clock,
    input  logic [IDX_W-1:0] i_rd_addr,
    output logic             o_rd_data,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_addr,
    input  logic             i_wr_data
);

    logic r_mem [2**IDX_W];
    logic r_rd_data;

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cov_sum_accumulator.sv
// Counts distinct coverage bins hit since the last clear sweep.
// state | meaning
// RUN   | accepting hits, 2-stage lookup/update pipeline active
// DRAIN | hits blocked, waiting for S1/S2 to empty
// CLEAR | sweeping bitmap to zero, one address per cycle
module cov_sum_accumulator
    import cov_acc_pkg::*;
#(
    parameter int IDX_W = 16,
    parameter int SUM_W = COV_SUM_W
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_cov_valid,
    input  logic [IDX_W-1:0] i_cov_idx,
    output logic             o_cov_ready,
    input  logic             i_clear_req,
    output logic             o_clear_done,
    output logic [SUM_W-1:0] o_cov_sum,
    output logic             o_busy
);

    localparam logic [IDX_W-1:0] PTR_LAST = '1;

    cov_acc_state_e       r_state;
    cov_acc_state_e       w_state_nxt;
    logic [IDX_W-1:0]     r_ptr;
    logic                 r_s1_v;
    logic                 r_s2_v;
    logic                 r_prev_new;
    logic                 r_clear_done;
    logic [IDX_W-1:0]     r_s1_idx;
    logic [IDX_W-1:0]     r_s2_idx;
    logic [IDX_W-1:0]     r_prev_idx;
    logic [SUM_W-1:0]     r_sum;
    logic                 w_accept;
    logic                 w_rd_bit;
    logic                 w_new;
    logic                 w_wr_en;
    logic                 w_wr_data;
    logic [IDX_W-1:0]     w_wr_addr;
    logic [COV_SUM_W-1:0] w_sum_inc;

    assign w_accept  = i_cov_valid && (r_state == RUN);
    // The previous S2 write lands on the same edge this S2 bit was read, so check it directly.
    assign w_new     = r_s2_v && !w_rd_bit && !(r_prev_new && (r_prev_idx == r_s2_idx));
    assign w_sum_inc = sat_inc(COV_SUM_W'(r_sum), SUM_W);

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = w_new;
        w_wr_addr   = r_s2_idx;
        w_wr_data   = 1'b1;
        case (r_state)
            RUN:     if (i_clear_req) w_state_nxt = DRAIN;
            DRAIN:   if (!r_s1_v && !r_s2_v) w_state_nxt = CLEAR;
            CLEAR:   if (r_ptr == PTR_LAST) w_state_nxt = RUN;
            default: w_state_nxt = CLEAR;
        endcase
        if (r_state == CLEAR) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_ptr;
            w_wr_data = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= CLEAR;
            r_ptr        <= '0;
            r_s1_v       <= 1'b0;
            r_s2_v       <= 1'b0;
            r_prev_new   <= 1'b0;
            r_clear_done <= 1'b0;
            r_sum        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_clear_done <= (r_state == CLEAR) && (w_state_nxt == RUN);
            r_ptr        <= (r_state == CLEAR) ? r_ptr + 1'b1 : '0;
            r_s1_v       <= w_accept;
            r_s2_v       <= r_s1_v;
            r_prev_new   <= w_new;
            if ((r_state == DRAIN) && (w_state_nxt == CLEAR)) begin
                r_sum <= '0;
            end else if (w_new) begin
                r_sum <= w_sum_inc[SUM_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_accept) begin
            r_s1_idx <= i_cov_idx;
        end
        r_s2_idx   <= r_s1_idx;
        r_prev_idx <= r_s2_idx;
    end

    cov_bitmap_ram #(
        .IDX_W (IDX_W)
    ) u_bitmap (
        .i_clock   (i_clock),
        .i_rd_addr (r_s1_idx),
        .o_rd_data (w_rd_bit),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data)
    );

    assign o_cov_ready  = (r_state == RUN);
    assign o_busy       = (r_state != RUN);
    assign o_clear_done = r_clear_done;
    assign o_cov_sum    = r_sum;

endmodule
